svnet_reg_fifo_multi: RTL and testbench
=======================================

# svnet_reg_fifo_multi

Register-based FIFO generalised to multiple write and read lanes per cycle, with flush, almost-full/almost-empty thresholds and a sticky protocol-error flag. Sits between layer stages of the convolution pipeline that produce or consume several words per cycle, e.g. a 2-pixel-wide feature stream feeding a 1-pixel-wide MAC. Storage is a flop array; there is no RAM inference.

## Interface
- WIDTH, 1: bits per entry.
- DEPTH, 4: number of entries; must be >= max(WR_LANES, RD_LANES).
- WR_LANES, 1: maximum entries written per cycle.
- RD_LANES, 1: maximum entries read per cycle; also the number of presented output lanes.
- ALMOST_FULL, DEPTH-1: almost_full asserts when used_space >= ALMOST_FULL.
- ALMOST_EMPTY, 1: almost_empty asserts when used_space <= ALMOST_EMPTY.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discards all contents and clears error.
- free_space  out  $clog2(DEPTH)+1  DEPTH - used_space.
- almost_full  out  1  threshold flag.
- write_count  in  $clog2(WR_LANES)+1  number of lanes written this cycle, lane 0 first.
- write_data  in  WR_LANES x WIDTH  lane i is the i-th entry pushed.
- used_space  out  $clog2(DEPTH)+1  entries held.
- almost_empty  out  1  threshold flag.
- read_data  out  RD_LANES x WIDTH  lane i is the i-th oldest entry; zero when i >= used_space.
- read_count  in  $clog2(RD_LANES)+1  number of lanes popped this cycle, lane 0 first.
- error  out  1  sticky protocol-violation flag.

## Operation
- Storage is entries[0..DEPTH-1], entries[0] the oldest; read_data lane i = entries[i].
- Each cycle: pop r = min(read_count, RD_LANES, used_space) entries from the head (shift down by r, zeros shift in at the top); append w = min(write_count, WR_LANES, free_space) entries at index used_space - r.
- Write credit comes from registered free_space only; space freed by a same-cycle read is not usable until the next cycle.
- Violations: write_count > free_space, write_count > WR_LANES, read_count > used_space or read_count > RD_LANES set error; the operation is clamped as above, never corrupting stored data.
- flush has priority: write and read that cycle are ignored, all entries zeroed, used_space -> 0, error -> 0.
- almost_full / almost_empty are combinational from registered used_space.
- Reset values: used_space 0, free_space DEPTH, almost_full (ALMOST_FULL == 0), almost_empty 1, read_data all zero, error 0.
- Reset mid-operation: contents lost immediately; no entry survives.

## Timing
- Write-to-read latency 1: an entry written in cycle n appears on read_data in cycle n+1 (no fall-through).
- Write-to-write and read-to-read delay 1: back-to-back full-rate operation every cycle.
- used_space, free_space and flags reflect the registered state; they update one cycle after the causing write/read/flush.
- Simultaneous write and read when full: read proceeds, write is clamped to 0 and error sets.
- Simultaneous write and read when empty: write proceeds, read clamped to 0, error sets.
- No combinational path from write_count/read_count to any output.

## Structure
- Shared package svnet_pkg gains function svnet_count_width(n) = $clog2(n)+1, used for all count/space ports.
- One sub-module: svnet_reg_fifo_multi_next, purely combinational, computing the next entries image from entries, used_space, r, w and write_data; the top holds the registers, clamping, flags and error.
- A companion instantiation macro SVNET_REG_FIFO_MULTI(name, depth, wr_lanes, rd_lanes) mirrors the single-lane one.

## Test plan
- WIDTH=8, DEPTH=4, WR=RD=2; reset -> used_space 0, free_space 4, almost_empty 1, read_data {0,0}, error 0.
- Write 2 lanes {0x11,0x22}, then {0x33,0x44} -> next cycles used_space 2 then 4, almost_full 1, read_data {0x11,0x22}.
- When full, read 2 and write 2 {0x55,0x66} same cycle -> write dropped, error 1, used_space 2, read_data {0x33,0x44}.
- Used 1 holding 0xAA; read 1 + write 2 {0xBB,0xCC} -> used_space 2, read_data {0xBB,0xCC}, error 0.
- Empty, read_count 1 -> error 1, used_space stays 0; then flush with write_count 2 -> used_space 0, error 0.
- Assert rst_n low mid-stream with used_space 3 -> outputs return to reset values asynchronously, before next clk edge.

Source files
------------

// File: rtl/svnet_pkg.sv
// Shared svnet helpers: count-width function and the multi-lane FIFO instantiation macro.
package svnet_pkg;

   function automatic int svnet_count_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

`ifndef SVNET_REG_FIFO_MULTI
`define SVNET_REG_FIFO_MULTI(name, depth, wr_lanes, rd_lanes) \
   svnet_reg_fifo_multi #(.DEPTH(depth), .WR_LANES(wr_lanes), .RD_LANES(rd_lanes)) name (.*);
`endif

// File: rtl/svnet_reg_fifo_multi_next.sv
// Combinational next-image of the FIFO storage: pop r from the head, append w behind the survivors.
module svnet_reg_fifo_multi_next
   import svnet_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int DEPTH    = 4,
   parameter int WR_LANES = 1,
   localparam int CW      = svnet_count_width(DEPTH)
) (
   input  logic [DEPTH-1:0][WIDTH-1:0]    entries,
   input  logic [CW-1:0]                  used_space,
   input  logic [CW-1:0]                  r,
   input  logic [CW-1:0]                  w,
   input  logic [WR_LANES-1:0][WIDTH-1:0] write_data,
   output logic [DEPTH-1:0][WIDTH-1:0]    next_entries
);

   // Constant-index loops keep the shift and append muxes free of variable indexing.
   always_comb begin
      int base;
      base = int'(used_space) - int'(r);
      for (int i = 0; i < DEPTH; i++) begin
         next_entries[i] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            if (j == i + int'(r)) next_entries[i] = entries[j];
         end
         for (int k = 0; k < WR_LANES; k++) begin
            if ((i == base + k) && (k < int'(w))) next_entries[i] = write_data[k];
         end
      end
   end

endmodule

// File: rtl/svnet_reg_fifo_multi.sv
// Multi-lane register FIFO: holds the storage, clamps lane counts, derives flags and the sticky error.
module svnet_reg_fifo_multi
   import svnet_pkg::*;
#(
   parameter int WIDTH        = 1,
   parameter int DEPTH        = 4,
   parameter int WR_LANES     = 1,
   parameter int RD_LANES     = 1,
   parameter int ALMOST_FULL  = DEPTH - 1,
   parameter int ALMOST_EMPTY = 1,
   localparam int CW          = svnet_count_width(DEPTH),
   localparam int WCW         = svnet_count_width(WR_LANES),
   localparam int RCW         = svnet_count_width(RD_LANES)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   output logic [CW-1:0]                  free_space,
   output logic                           almost_full,
   input  logic [WCW-1:0]                 write_count,
   input  logic [WR_LANES-1:0][WIDTH-1:0] write_data,
   output logic [CW-1:0]                  used_space,
   output logic                           almost_empty,
   output logic [RD_LANES-1:0][WIDTH-1:0] read_data,
   input  logic [RCW-1:0]                 read_count,
   output logic                           error
);

   logic [DEPTH-1:0][WIDTH-1:0] entries;
   logic [DEPTH-1:0][WIDTH-1:0] next_entries;
   logic [CW-1:0]               r;
   logic [CW-1:0]               w;
   logic                        violation;

   // Write credit is taken from the registered free space only, so a same-cycle pop never frees room.
   always_comb begin
      int used_i;
      int free_i;
      int wc_i;
      int rc_i;
      int r_i;
      int w_i;
      used_i = int'(used_space);
      free_i = DEPTH - used_i;
      wc_i   = int'(write_count);
      rc_i   = int'(read_count);
      r_i    = rc_i;
      if (r_i > RD_LANES) r_i = RD_LANES;
      if (r_i > used_i)   r_i = used_i;
      w_i    = wc_i;
      if (w_i > WR_LANES) w_i = WR_LANES;
      if (w_i > free_i)   w_i = free_i;
      violation = (wc_i > free_i) || (wc_i > WR_LANES) || (rc_i > used_i) || (rc_i > RD_LANES);
      r = CW'(r_i);
      w = CW'(w_i);
   end

   svnet_reg_fifo_multi_next #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .WR_LANES (WR_LANES)
   ) u_next (
      .entries      (entries),
      .used_space   (used_space),
      .r            (r),
      .w            (w),
      .write_data   (write_data),
      .next_entries (next_entries)
   );

   // Flush wins over any same-cycle traffic and also clears the sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries    <= '0;
         used_space <= '0;
         error      <= 1'b0;
      end else if (flush) begin
         entries    <= '0;
         used_space <= '0;
         error      <= 1'b0;
      end else begin
         entries    <= next_entries;
         used_space <= used_space - r + w;
         error      <= error | violation;
      end
   end

   assign free_space   = CW'(DEPTH) - used_space;
   assign almost_full  = int'(used_space) >= ALMOST_FULL;
   assign almost_empty = int'(used_space) <= ALMOST_EMPTY;

   always_comb begin
      for (int i = 0; i < RD_LANES; i++) read_data[i] = entries[i];
   end

endmodule

// File: tb/tb_svnet_reg_fifo_multi.sv
// Self-checking bench for svnet_reg_fifo_multi (WIDTH 8, DEPTH 4, two write and two read lanes).
module tb_svnet_reg_fifo_multi;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic [2:0]      free_space;
   logic            almost_full;
   logic [1:0]      write_count;
   logic [1:0][7:0] write_data;
   logic [2:0]      used_space;
   logic            almost_empty;
   logic [1:0][7:0] read_data;
   logic [1:0]      read_count;
   logic            error;

   int check_cnt = 0;
   int pass_cnt  = 0;

   byte unsigned model_q[$];
   bit           model_err;

   svnet_reg_fifo_multi #(
      .WIDTH    (8),
      .DEPTH    (4),
      .WR_LANES (2),
      .RD_LANES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .free_space   (free_space),
      .almost_full  (almost_full),
      .write_count  (write_count),
      .write_data   (write_data),
      .used_space   (used_space),
      .almost_empty (almost_empty),
      .read_data    (read_data),
      .read_count   (read_count),
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_cycle(input logic fl, input logic [1:0] wc, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [1:0] rc);
      flush         = fl;
      write_count   = wc;
      write_data[0] = d0;
      write_data[1] = d1;
      read_count    = rc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      do_cycle(0, 0, 8'h00, 8'h00, 0);
      do_cycle(0, 0, 8'h00, 8'h00, 0);
      rst_n = 1'b1;
      do_cycle(0, 0, 8'h00, 8'h00, 0);
      check_cnt++; if (used_space !== 3'd0) $display("FAIL reset_used got %0d want 0", used_space); else pass_cnt++;
      check_cnt++; if (free_space !== 3'd4) $display("FAIL reset_free got %0d want 4", free_space); else pass_cnt++;
      check_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty); else pass_cnt++;
      check_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full); else pass_cnt++;
      check_cnt++; if (read_data !== 16'h0000) $display("FAIL reset_rd got %h want 0000", read_data); else pass_cnt++;
      check_cnt++; if (error !== 1'b0) $display("FAIL reset_err got %b want 0", error); else pass_cnt++;
   endtask

   task automatic test_fill();
      do_cycle(0, 2, 8'h11, 8'h22, 0);
      check_cnt++; if (used_space !== 3'd2) $display("FAIL fill1_used got %0d want 2", used_space); else pass_cnt++;
      check_cnt++; if (read_data !== {8'h22, 8'h11}) $display("FAIL fill1_rd got %h want 2211", read_data); else pass_cnt++;
      do_cycle(0, 2, 8'h33, 8'h44, 0);
      check_cnt++; if (used_space !== 3'd4) $display("FAIL fill2_used got %0d want 4", used_space); else pass_cnt++;
      check_cnt++; if (free_space !== 3'd0) $display("FAIL fill2_free got %0d want 0", free_space); else pass_cnt++;
      check_cnt++; if (almost_full !== 1'b1) $display("FAIL fill2_af got %b want 1", almost_full); else pass_cnt++;
      check_cnt++; if (read_data !== {8'h22, 8'h11}) $display("FAIL fill2_rd got %h want 2211", read_data); else pass_cnt++;
      check_cnt++; if (error !== 1'b0) $display("FAIL fill2_err got %b want 0", error); else pass_cnt++;
   endtask

   task automatic test_full_rw();
      do_cycle(0, 2, 8'h55, 8'h66, 2);
      check_cnt++; if (used_space !== 3'd2) $display("FAIL fullrw_used got %0d want 2", used_space); else pass_cnt++;
      check_cnt++; if (read_data !== {8'h44, 8'h33}) $display("FAIL fullrw_rd got %h want 4433", read_data); else pass_cnt++;
      check_cnt++; if (error !== 1'b1) $display("FAIL fullrw_err got %b want 1", error); else pass_cnt++;
      do_cycle(0, 0, 8'h00, 8'h00, 2);
      check_cnt++; if (used_space !== 3'd0) $display("FAIL drain_used got %0d want 0", used_space); else pass_cnt++;
      check_cnt++; if (read_data !== 16'h0000) $display("FAIL drain_rd got %h want 0000", read_data); else pass_cnt++;
      check_cnt++; if (error !== 1'b1) $display("FAIL sticky_err got %b want 1", error); else pass_cnt++;
   endtask

   task automatic test_partial();
      do_cycle(1, 0, 8'h00, 8'h00, 0);
      do_cycle(0, 1, 8'hAA, 8'h00, 0);
      check_cnt++; if (read_data !== {8'h00, 8'hAA}) $display("FAIL part1_rd got %h want 00aa", read_data); else pass_cnt++;
      do_cycle(0, 2, 8'hBB, 8'hCC, 1);
      check_cnt++; if (used_space !== 3'd2) $display("FAIL part2_used got %0d want 2", used_space); else pass_cnt++;
      check_cnt++; if (read_data !== {8'hCC, 8'hBB}) $display("FAIL part2_rd got %h want ccbb", read_data); else pass_cnt++;
      check_cnt++; if (error !== 1'b0) $display("FAIL part2_err got %b want 0", error); else pass_cnt++;
   endtask

   task automatic test_empty_flush();
      do_cycle(1, 0, 8'h00, 8'h00, 0);
      do_cycle(0, 0, 8'h00, 8'h00, 1);
      check_cnt++; if (error !== 1'b1) $display("FAIL emptyrd_err got %b want 1", error); else pass_cnt++;
      check_cnt++; if (used_space !== 3'd0) $display("FAIL emptyrd_used got %0d want 0", used_space); else pass_cnt++;
      do_cycle(1, 2, 8'h77, 8'h88, 0);
      check_cnt++; if (used_space !== 3'd0) $display("FAIL flush_used got %0d want 0", used_space); else pass_cnt++;
      check_cnt++; if (error !== 1'b0) $display("FAIL flush_err got %b want 0", error); else pass_cnt++;
      check_cnt++; if (read_data !== 16'h0000) $display("FAIL flush_rd got %h want 0000", read_data); else pass_cnt++;
   endtask

   task automatic test_random();
      logic            fl;
      logic [1:0]      wc;
      logic [1:0]      rc;
      logic [7:0]      d0;
      logic [7:0]      d1;
      logic [1:0][7:0] exp_rd;
      int              used;
      int              free;
      int              rn;
      int              wn;
      model_q.delete();
      model_err = 0;
      do_cycle(1, 0, 8'h00, 8'h00, 0);
      for (int n = 0; n < 300; n++) begin
         fl = ($urandom_range(0, 15) == 0);
         wc = 2'($urandom_range(0, 3));
         rc = 2'($urandom_range(0, 3));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         used = model_q.size();
         free = 4 - used;
         if (fl) begin
            model_q.delete();
            model_err = 0;
         end else begin
            if (wc > free || wc > 2 || rc > used || rc > 2) model_err = 1;
            rn = (rc > 2) ? 2 : int'(rc);
            if (rn > used) rn = used;
            wn = (wc > 2) ? 2 : int'(wc);
            if (wn > free) wn = free;
            for (int k = 0; k < rn; k++) void'(model_q.pop_front());
            if (wn > 0) model_q.push_back(d0);
            if (wn > 1) model_q.push_back(d1);
         end
         do_cycle(fl, wc, d0, d1, rc);
         for (int i = 0; i < 2; i++) exp_rd[i] = (i < model_q.size()) ? model_q[i] : 8'h00;
         check_cnt++; if (int'(used_space) != model_q.size()) $display("FAIL rnd_used n=%0d got %0d want %0d", n, used_space, model_q.size()); else pass_cnt++;
         check_cnt++; if (int'(free_space) != 4 - model_q.size()) $display("FAIL rnd_free n=%0d got %0d want %0d", n, free_space, 4 - model_q.size()); else pass_cnt++;
         check_cnt++; if (almost_full !== (model_q.size() >= 3)) $display("FAIL rnd_af n=%0d got %b", n, almost_full); else pass_cnt++;
         check_cnt++; if (almost_empty !== (model_q.size() <= 1)) $display("FAIL rnd_ae n=%0d got %b", n, almost_empty); else pass_cnt++;
         check_cnt++; if (read_data !== exp_rd) $display("FAIL rnd_rd n=%0d got %h want %h", n, read_data, exp_rd); else pass_cnt++;
         check_cnt++; if (error !== model_err) $display("FAIL rnd_err n=%0d got %b want %b", n, error, model_err); else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      do_cycle(1, 0, 8'h00, 8'h00, 0);
      do_cycle(0, 2, 8'h01, 8'h02, 0);
      do_cycle(0, 1, 8'h03, 8'h00, 0);
      check_cnt++; if (used_space !== 3'd3) $display("FAIL pre_rst_used got %0d want 3", used_space); else pass_cnt++;
      do_cycle(0, 0, 8'h00, 8'h00, 0);
      #2 rst_n = 1'b0;
      #1;
      check_cnt++; if (used_space !== 3'd0) $display("FAIL arst_used got %0d want 0", used_space); else pass_cnt++;
      check_cnt++; if (free_space !== 3'd4) $display("FAIL arst_free got %0d want 4", free_space); else pass_cnt++;
      check_cnt++; if (almost_empty !== 1'b1) $display("FAIL arst_ae got %b want 1", almost_empty); else pass_cnt++;
      check_cnt++; if (read_data !== 16'h0000) $display("FAIL arst_rd got %h want 0000", read_data); else pass_cnt++;
      check_cnt++; if (error !== 1'b0) $display("FAIL arst_err got %b want 0", error); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle(0, 0, 8'h00, 8'h00, 0);
      check_cnt++; if (used_space !== 3'd0) $display("FAIL post_rst_used got %0d want 0", used_space); else pass_cnt++;
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      write_count = '0;
      write_data  = '0;
      read_count  = '0;
      test_reset();
      test_fill();
      test_full_rw();
      test_partial();
      test_empty_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
